// File: rtl/imem_resp.sv
// Multi-cycle instruction memory with request/busy/done handshake and a loader write port.
// Optional IMEM_HIT_BYPASS_EN adds a one-entry hit bypass for repeated reads of one word.
module imem_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [15:0] rd_addr,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        rd_err,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    mis_q;
    logic [15:0]             mem [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic [DEPTH_LOG2-1:0]   ld_idx;
    logic                    unused_addr;

    assign rd_idx      = rd_addr[DEPTH_LOG2:1];
    assign ld_idx      = ld_addr[DEPTH_LOG2:1];
    assign unused_addr = ^{rd_addr[15:DEPTH_LOG2+1], ld_addr[15:DEPTH_LOG2+1], ld_addr[0]};

`ifdef IMEM_HIT_BYPASS_EN
    logic [DEPTH_LOG2-1:0]   tag_q;
    logic                    tag_vld_q;
    logic                    hit;

    // A loader write to the tagged word on the accept edge disqualifies the hit.
    assign hit = tag_vld_q && !rd_addr[0] && (rd_idx == tag_q) && !(ld_en && ld_idx == tag_q);
`endif

    // Array is not reset; the write happens after the same-edge read (read-before-write).
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            mis_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 16'h0000;
            rd_err    <= 1'b0;
`ifdef IMEM_HIT_BYPASS_EN
            tag_q     <= '0;
            tag_vld_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef IMEM_HIT_BYPASS_EN
            if (ld_en && ld_idx == tag_q) begin
                tag_vld_q <= 1'b0;
            end
`endif
            case (state_q)
                StIdle, StResp: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                    if (rd_req) begin
                        idx_q <= rd_idx;
                        mis_q <= rd_addr[0];
`ifdef IMEM_HIT_BYPASS_EN
                        if (hit) begin
                            state_q <= StResp;
                            done    <= 1'b1;
                            rd_err  <= 1'b0;
                        end else
`endif
                        if (LATENCY == 1) begin
                            state_q <= StResp;
                            done    <= 1'b1;
                            rd_data <= rd_addr[0] ? 16'h0000 : mem[rd_idx];
                            rd_err  <= rd_addr[0];
`ifdef IMEM_HIT_BYPASS_EN
                            tag_q     <= rd_idx;
                            tag_vld_q <= !rd_addr[0] && !(ld_en && ld_idx == rd_idx);
`endif
                        end else begin
                            state_q <= StWait;
                            busy    <= 1'b1;
                            cnt_q   <= 4'(LATENCY - 2);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rd_data <= mis_q ? 16'h0000 : mem[idx_q];
                        rd_err  <= mis_q;
`ifdef IMEM_HIT_BYPASS_EN
                        // Misaligned completions zero rd_data, so the tag must not survive them.
                        tag_q     <= idx_q;
                        tag_vld_q <= !mis_q && !(ld_en && ld_idx == idx_q);
`endif
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_resp.sv
// Directed self-checking bench for imem_resp at default parameters (LATENCY=3).
// Optional IMEM_HIT_BYPASS_EN section checks the one-cycle hit path.
module tb_imem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;
    logic        rd_err;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    imem_resp dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .rd_err  (rd_err),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_data", {16'b0, rd_data}, 32'h0000);
        chk("rst_err", {31'b0, rd_err}, 32'd0);
        rst = 1'b0;

        // Load two words.
        ld_en = 1'b1; ld_addr = 16'h0000; ld_data = 16'hA5C3;
        step();
        ld_addr = 16'h0002; ld_data = 16'h1234;
        step();
        ld_en = 1'b0;

        // Basic read of 0x0002.
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0; rd_addr = 16'h0000;
        chk("rd1_busy_c1", {31'b0, busy}, 32'd1);
        chk("rd1_done_c1", {31'b0, done}, 32'd0);
        step();
        chk("rd1_busy_c2", {31'b0, busy}, 32'd1);
        chk("rd1_done_c2", {31'b0, done}, 32'd0);
        step();
        chk("rd1_busy_c3", {31'b0, busy}, 32'd0);
        chk("rd1_done_c3", {31'b0, done}, 32'd1);
        chk("rd1_data", {16'b0, rd_data}, 32'h1234);
        chk("rd1_err", {31'b0, rd_err}, 32'd0);
        step();
        chk("rd1_done_off", {31'b0, done}, 32'd0);
        chk("rd1_hold", {16'b0, rd_data}, 32'h1234);

        // Back-to-back: 0x0000 then 0x0002 with rd_req held.
        rd_req = 1'b1; rd_addr = 16'h0000;
        step();
        rd_addr = 16'h0002;
        chk("b2b_busy_a", {31'b0, busy}, 32'd1);
        step();
        chk("b2b_done_a1", {31'b0, done}, 32'd0);
        step();
        chk("b2b_done_a", {31'b0, done}, 32'd1);
        chk("b2b_data_a", {16'b0, rd_data}, 32'hA5C3);
        step();
        chk("b2b_done_gap", {31'b0, done}, 32'd0);
        chk("b2b_busy_b", {31'b0, busy}, 32'd1);
        step();
        chk("b2b_done_b1", {31'b0, done}, 32'd0);
        step();
        rd_req = 1'b0;
        chk("b2b_done_b", {31'b0, done}, 32'd1);
        chk("b2b_data_b", {16'b0, rd_data}, 32'h1234);
        step();
        chk("b2b_idle", {31'b0, done | busy}, 32'd0);

        // Misaligned read, then an aligned read clears rd_err.
        rd_req = 1'b1; rd_addr = 16'h0003;
        step();
        rd_req = 1'b0;
        step();
        chk("mis_done_early", {31'b0, done}, 32'd0);
        step();
        chk("mis_done", {31'b0, done}, 32'd1);
        chk("mis_err", {31'b0, rd_err}, 32'd1);
        chk("mis_data", {16'b0, rd_data}, 32'h0000);
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0;
        chk("mis_hold_err", {31'b0, rd_err}, 32'd1);
        step();
        step();
        chk("al_done", {31'b0, done}, 32'd1);
        chk("al_err", {31'b0, rd_err}, 32'd0);
        chk("al_data", {16'b0, rd_data}, 32'h1234);

        // Wrap 0x0800 -> index 0, with a same-edge write of index 0.
        rd_req = 1'b1; rd_addr = 16'h0800;
        step();
        rd_req = 1'b0;
        step();
        ld_en = 1'b1; ld_addr = 16'h0000; ld_data = 16'hBEEF;
        step();
        ld_en = 1'b0;
        chk("wrap_done", {31'b0, done}, 32'd1);
        chk("wrap_old", {16'b0, rd_data}, 32'hA5C3);
        rd_req = 1'b1; rd_addr = 16'h0000;
        step();
        rd_req = 1'b0;
        step();
        step();
        chk("wrap_new_done", {31'b0, done}, 32'd1);
        chk("wrap_new", {16'b0, rd_data}, 32'hBEEF);

        // Reset one cycle after accept drops the request.
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        chk("mrst_data", {16'b0, rd_data}, 32'h0000);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("mrst_no_done%0d", i), {31'b0, done | busy}, 32'd0);
        end
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0;
        chk("post_busy", {31'b0, busy}, 32'd1);
        step();
        step();
        chk("post_done", {31'b0, done}, 32'd1);
        chk("post_data", {16'b0, rd_data}, 32'h1234);
        step();

        // Repeat read of 0x0002: one cycle with the bypass, full latency without.
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0;
`ifdef IMEM_HIT_BYPASS_EN
        chk("hit_done", {31'b0, done}, 32'd1);
        chk("hit_busy", {31'b0, busy}, 32'd0);
        chk("hit_data", {16'b0, rd_data}, 32'h1234);
`else
        chk("rep_busy", {31'b0, busy}, 32'd1);
        step();
        step();
        chk("rep_done", {31'b0, done}, 32'd1);
        chk("rep_data", {16'b0, rd_data}, 32'h1234);
`endif
        step();
        ld_en = 1'b1; ld_addr = 16'h0002; ld_data = 16'h5678;
        step();
        ld_en = 1'b0;
        rd_req = 1'b1; rd_addr = 16'h0002;
        step();
        rd_req = 1'b0;
        chk("inv_busy", {31'b0, busy}, 32'd1);
        chk("inv_done_c1", {31'b0, done}, 32'd0);
        step();
        step();
        chk("inv_done", {31'b0, done}, 32'd1);
        chk("inv_data", {16'b0, rd_data}, 32'h5678);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
